// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with trap entry/MRET handling,
// 64-bit cycle/instret counters and illegal-access flagging.
// Each read access costs one stall cycle. The read data is registered at the
// end of that stall cycle and is presented in the following (BUSY) cycle.
module csr_trap_unit #(
  parameter int          XLEN            = 32,
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_1000,
  parameter bit          ENABLE_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_read_enable,
  input  logic [11:0]     csr_read_address,
  input  logic            csr_write_enable,
  input  logic [11:0]     csr_write_address,
  input  logic [XLEN-1:0] csr_write_data,
  input  logic            trapped,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_value,
  input  logic            mret,
  input  logic            retire,
  output logic [XLEN-1:0] csr_read_out,
  output logic            csr_ready,
  output logic            csr_illegal,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mret_target,
  output logic            mstatus_mie
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Clears bits [1:0] for mtvec/mepc.
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t state_q, state_d;
  logic   capture;

  logic [XLEN-1:0]   mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic              mie_q, mpie_q;
  logic [2*XLEN-1:0] mcycle_q, minstret_q;

  logic [XLEN-1:0] rd_data;
  logic            rd_known, wr_legal, wr_ok, acc_illegal;

  function automatic logic is_known(input logic [11:0] a);
    case (a)
      12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h301, 12'h300, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: is_known = 1'b1;
      default:                            is_known = 1'b0;
    endcase
  endfunction

  // Writes to [11:10]=2'b11 space (read-only) or unknown addresses are dropped.
  assign rd_known    = is_known(csr_read_address);
  assign wr_legal    = is_known(csr_write_address) && (csr_write_address[11:10] != 2'b11);
  assign wr_ok       = csr_write_enable && wr_legal;
  // A write strobed alongside the access (CSRRW-style) also makes it illegal.
  assign acc_illegal = !rd_known || (csr_write_enable && !wr_legal);

  // Read mux over pre-update state; unknown addresses read as zero.
  always_comb begin
    rd_data = '0;
    case (csr_read_address)
      12'hF11: rd_data = XLEN'(32'h5256_4B43);
      12'hF12: rd_data = XLEN'(32'h3436_5335);
      12'hF13: rd_data = XLEN'(32'h3436_4931);
      12'hF14: rd_data = XLEN'(32'h524B_4330);
      12'h301: rd_data = XLEN'(32'h4000_0100);
      12'h300: rd_data = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
      12'h305: rd_data = mtvec_q;
      12'h340: rd_data = mscratch_q;
      12'h341: rd_data = mepc_q;
      12'h342: rd_data = mcause_q;
      12'h343: rd_data = mtval_q;
      12'hB00, 12'hC00: rd_data = ENABLE_COUNTERS ? mcycle_q[XLEN-1:0]        : '0;
      12'hB80, 12'hC80: rd_data = ENABLE_COUNTERS ? mcycle_q[2*XLEN-1:XLEN]   : '0;
      12'hB02, 12'hC02: rd_data = ENABLE_COUNTERS ? minstret_q[XLEN-1:0]      : '0;
      12'hB82, 12'hC82: rd_data = ENABLE_COUNTERS ? minstret_q[2*XLEN-1:XLEN] : '0;
      default: rd_data = '0;
    endcase
  end

  // Access state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Access FSM: stall while IDLE with a request, release in BUSY.
  always_comb begin
    state_d   = state_q;
    csr_ready = 1'b1;
    capture   = 1'b0;
    case (state_q)
      IDLE: if (csr_read_enable) begin
        csr_ready = 1'b0;
        capture   = 1'b1;
        state_d   = BUSY;
      end
      BUSY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CSR state, trap/MRET sequencing, counters and registered read result.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtvec_q      <= XLEN'(MTVEC_RESET) & ALIGN_MASK;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
      csr_read_out <= '0;
      csr_illegal  <= 1'b0;
    end else begin
      if (capture) begin
        csr_illegal  <= acc_illegal;
        csr_read_out <= acc_illegal ? '0 : rd_data;
      end

      // trap beats mret beats a software write for the trap-owned CSRs
      if (trapped) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr_ok && csr_write_address == 12'h300) begin
        mie_q  <= csr_write_data[3];
        mpie_q <= csr_write_data[7];
      end

      if (trapped) begin
        mepc_q   <= trap_pc & ALIGN_MASK;
        mcause_q <= trap_cause;
        mtval_q  <= trap_value;
      end else if (wr_ok) begin
        if (csr_write_address == 12'h341) mepc_q   <= csr_write_data & ALIGN_MASK;
        if (csr_write_address == 12'h342) mcause_q <= csr_write_data;
        if (csr_write_address == 12'h343) mtval_q  <= csr_write_data;
      end

      if (wr_ok && csr_write_address == 12'h305) mtvec_q    <= csr_write_data & ALIGN_MASK;
      if (wr_ok && csr_write_address == 12'h340) mscratch_q <= csr_write_data;

      // a write to either half wins over that cycle's increment
      if (ENABLE_COUNTERS) begin
        if (wr_ok && csr_write_address == 12'hB00)      mcycle_q[XLEN-1:0]      <= csr_write_data;
        else if (wr_ok && csr_write_address == 12'hB80) mcycle_q[2*XLEN-1:XLEN] <= csr_write_data;
        else                                            mcycle_q <= mcycle_q + 1'b1;

        if (wr_ok && csr_write_address == 12'hB02)      minstret_q[XLEN-1:0]      <= csr_write_data;
        else if (wr_ok && csr_write_address == 12'hB82) minstret_q[2*XLEN-1:XLEN] <= csr_write_data;
        else if (retire)                                minstret_q <= minstret_q + 1'b1;
      end
    end
  end

  assign trap_target = mtvec_q;
  assign mret_target = mepc_q;
  assign mstatus_mie = mie_q;

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Parametrised machine-mode CSR block for the RV32 cores; successor to the fixed single-stall CSR file. It adds mstatus.MIE/MPIE trap-entry and MRET semantics, mscratch/mtval, 64-bit mcycle/minstret counters with user-level read-only shadows, and illegal-access flagging. It sits beside the register file in the execute stage and feeds trap/return targets to the PC logic.

## Interface
- XLEN, 32, data width; only 32 is supported, and counters are split into low/high halves.
- MTVEC_RESET, 32'h0000_1000, mtvec reset value; bits [1:0] are ignored.
- ENABLE_COUNTERS, 1, when 0: cycle/instret CSRs read as 0, writes are ignored, and accesses are not illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- csr_read_enable  in  1  CSR access request; held with csr_read_address until csr_ready=1.
- csr_read_address  in  12  CSR read address.
- csr_write_enable  in  1  write strobe, one cycle.
- csr_write_address  in  12  write address.
- csr_write_data  in  XLEN  write data.
- trapped  in  1  trap entry strobe.
- trap_pc  in  XLEN  faulting PC; captured to mepc.
- trap_cause  in  XLEN  captured to mcause.
- trap_value  in  XLEN  captured to mtval.
- mret  in  1  MRET strobe.
- retire  in  1  one instruction retired this cycle.
- csr_read_out  out  XLEN  registered read data.
- csr_ready  out  1  low only in the stall cycle of an access.
- csr_illegal  out  1  registered; valid with csr_read_out.
- trap_target  out  XLEN  equals {mtvec[31:2],2'b00}.
- mret_target  out  XLEN  equals mepc.
- mstatus_mie  out  1  current value of MIE.

## Operation
- Read-only constants: mvendorid F11=5256_4B43, marchid F12=3436_5335, mimpid F13=3436_4931, mhartid F14=524B_4330, misa 301=4000_0100.
- mstatus (300):
  - Reads {19'b0, MPP=2'b11, 3'b0, MPIE, 3'b0, MIE, 3'b0}.
  - Writes update bits 3 and 7 only.
- Read/write CSRs: mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343.
  - mtvec and mepc force bits [1:0] to 0 on every write.
- Counters:
  - mcycle B00/B80 (low/high): +1 every non-reset cycle.
  - minstret B02/B82 (low/high): +1 when retire=1.
  - Both are 64-bit and wrap from FFFF_FFFF_FFFF_FFFF to 0.
  - Read-only shadows: cycle C00/C80, instret C02/C82.
  - A CSR write to either half replaces that half; the increment is dropped in that cycle.
- Illegal access, defined as either of:
  - an address not listed above;
  - a write whose address has [11:10]=2'b11.
  - Effect: no state change, csr_read_out=0, csr_illegal=1.
- Trap entry (trapped=1):
  - mepc←{trap_pc[31:2],2'b00}, mcause←trap_cause, mtval←trap_value.
  - MPIE←MIE, MIE←0.
- MRET (mret=1): MIE←MPIE, MPIE←1.
- Priority in one cycle: trapped > mret > csr write for mstatus/mepc/mcause/mtval.
  - A CSR write to any other CSR still takes effect.
  - Counters increment regardless of traps.
- Reset:
  - mtvec=MTVEC_RESET; mepc, mcause, mtval, mscratch, MIE, MPIE = 0; both counters = 0.
  - csr_read_out=0, csr_illegal=0, internal busy flag=0, csr_ready=1.
  - Reset asserted mid-access aborts the access; the next cycle is idle.

## Timing
- States: IDLE, BUSY (1-bit flag).
- IDLE with csr_read_enable=1 in cycle N:
  - csr_ready=0 combinationally in cycle N.
  - At edge N→N+1: csr_read_out and csr_illegal are registered and state goes to BUSY.
  - The registered value is the CSR value before any same-cycle write/trap/increment.
- BUSY in cycle N+1: csr_ready=1 and data is valid. State returns to IDLE regardless of csr_read_enable.
  - A new access therefore stalls again from cycle N+2.
- csr_read_out and csr_illegal hold their values until the next access completes.
- Writes commit at the edge they are sampled and need no handshake. Read-after-write to the same CSR in the next access returns the new value.
- trap_target, mret_target and mstatus_mie reflect state registered at the previous edge. No combinational path from trapped or mret.
- Latency: exactly 1 stall cycle for every access, legal or illegal.

## Test plan
- Reset, then read 305 → csr_ready 1,0,1 over N-1..N+1; csr_read_out=0000_1000 at N+1.
- Write 341=0000_1237, then read 341 → 0000_1234. Read C00 twice 5 cycles apart → difference 5. Write C00 → csr_illegal=1, counter not disturbed.
- Set MIE via write 300=0000_0008; trapped with trap_pc=0000_2000, cause=0000_000B → next cycle mepc=0000_2000, mcause=B, mstatus reads 0000_1880, mstatus_mie=0. mret → mstatus reads 0000_1888.
- trapped and a CSR write to 341 in the same cycle → mepc = trap_pc. A write to 340 in that cycle is still committed.
- Write B00=FFFF_FFFF, B80=FFFF_FFFF → two cycles later (after the wrap) mcycle reads 0000_0001 / 0000_0000. Write B02 while retire=1 → minstret low = written value.
- Read 7C0 → csr_illegal=1, csr_read_out=0. Reset in the BUSY cycle → next cycle csr_ready=1, csr_read_out=0.
